// File: rtl/dm_load_unit.sv
// Data-memory load unit: issues one word-aligned DM read per aligned load,
// waits RD_LATENCY edges, then extracts and extends the addressed
// byte/half/word. Misaligned loads raise a one-cycle AdEL pulse instead.

package dm_load_pkg;
  // Wordmode encodings shared with the store-side byte-enable decoder.
  localparam logic [2:0] WM_WD = 3'd0;
  localparam logic [2:0] WM_HU = 3'd1;
  localparam logic [2:0] WM_HS = 3'd2;
  localparam logic [2:0] WM_BU = 3'd3;
  localparam logic [2:0] WM_BS = 3'd4;
endpackage

module dm_load_unit
  import dm_load_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_wordmode,
  input  logic [4:0]  req_dst,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  input  logic        ld_ready,
  output logic [31:0] ld_data,
  output logic [4:0]  ld_dst,
  output logic        adel,
  output logic [31:0] adel_addr
);

  localparam logic [3:0] LAT = 4'(RD_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  off_q;
  logic [2:0]  wm_q;
  logic [31:0] mem_addr_q;
  logic [31:0] ld_data_q;
  logic [4:0]  ld_dst_q;
  logic        adel_q;
  logic [31:0] adel_addr_q;

  logic        accept;
  logic        misaligned;
  logic        sample;

  // Words need both low address bits clear, halves only bit 0; anything
  // not recognised as half or byte is treated as a word.
  function automatic logic is_misaligned(input logic [2:0] wm, input logic [1:0] a);
    case (wm)
      WM_HU, WM_HS: return a[0];
      WM_BU, WM_BS: return 1'b0;
      default:      return |a;
    endcase
  endfunction

  // Select the addressed lane of the read word and zero/sign-extend it.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] a,
                                         input logic [2:0] wm);
    logic [15:0] half;
    logic [7:0]  byte_sel;
    half = a[1] ? w[31:16] : w[15:0];
    case (a)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
    case (wm)
      WM_HU:   return {16'h0000, half};
      WM_HS:   return {{16{half[15]}}, half};
      WM_BU:   return {24'h000000, byte_sel};
      WM_BS:   return {{24{byte_sel[7]}}, byte_sel};
      default: return w;
    endcase
  endfunction

  assign req_ready  = (state_q == S_IDLE);
  assign accept     = req_valid & req_ready;
  assign misaligned = is_misaligned(req_wordmode, req_addr[1:0]);

  // The read word is only looked at on this one edge.
  assign sample = ((state_q == S_ISSUE) && (RD_LATENCY == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd1));

  // Next-state and wait-counter logic.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !misaligned) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = LAT;
        state_d = (RD_LATENCY == 0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        if (ld_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request capture, AdEL pulse and load-result registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch
    // inside the clocked block; it also wins over a sample on the same edge.
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      off_q       <= 2'd0;
      wm_q        <= WM_WD;
      mem_addr_q  <= 32'h0;
      ld_data_q   <= 32'h0;
      ld_dst_q    <= 5'd0;
      adel_q      <= 1'b0;
      adel_addr_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adel_q  <= accept & misaligned;
      if (accept) begin
        off_q      <= req_addr[1:0];
        wm_q       <= req_wordmode;
        ld_dst_q   <= req_dst;
        mem_addr_q <= {req_addr[31:2], 2'b00};
      end
      if (accept && misaligned) adel_addr_q <= req_addr;
      if (sample) ld_data_q <= extend(mem_rdata, off_q, wm_q);
    end
  end

  assign mem_ren   = (state_q == S_ISSUE);
  assign mem_addr  = mem_addr_q;
  assign ld_valid  = (state_q == S_DONE);
  assign ld_data   = ld_data_q;
  assign ld_dst    = ld_dst_q;
  assign adel      = adel_q;
  assign adel_addr = adel_addr_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// Bench for dm_load_unit: three instances (RD_LATENCY 0, 1, 4) driven by
// directed and random loads, checked against an arithmetic reference model.

module tb_dm_load_unit;
  import dm_load_pkg::*;

  localparam int NI = 3;
  localparam int LATS [NI] = '{0, 1, 4};

  logic        clk;
  logic        reset;
  logic        req_valid    [NI];
  logic        req_ready    [NI];
  logic [31:0] req_addr     [NI];
  logic [2:0]  req_wordmode [NI];
  logic [4:0]  req_dst      [NI];
  logic        mem_ren      [NI];
  logic [31:0] mem_addr     [NI];
  logic [31:0] mem_rdata    [NI];
  logic        ld_valid     [NI];
  logic        ld_ready     [NI];
  logic [31:0] ld_data      [NI];
  logic [4:0]  ld_dst       [NI];
  logic        adel         [NI];
  logic [31:0] adel_addr    [NI];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dm_load_unit #(.RD_LATENCY(LATS[g])) u_dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_addr     (req_addr[g]),
      .req_wordmode (req_wordmode[g]),
      .req_dst      (req_dst[g]),
      .mem_ren      (mem_ren[g]),
      .mem_addr     (mem_addr[g]),
      .mem_rdata    (mem_rdata[g]),
      .ld_valid     (ld_valid[g]),
      .ld_ready     (ld_ready[g]),
      .ld_data      (ld_data[g]),
      .ld_dst       (ld_dst[g]),
      .adel         (adel[g]),
      .adel_addr    (adel_addr[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, signedness, alignment, result.
  function automatic int ref_size(input logic [2:0] wm);
    if (wm == WM_HU || wm == WM_HS) return 2;
    if (wm == WM_BU || wm == WM_BS) return 1;
    return 4;
  endfunction

  function automatic bit ref_signed(input logic [2:0] wm);
    return (wm == WM_HS || wm == WM_BS);
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] addr, input logic [2:0] wm);
    return (addr % ref_size(wm)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] wm);
    longint unsigned val, mask;
    int sz, off;
    sz   = ref_size(wm);
    off  = int'(addr % 4);
    mask = (64'd1 << (8 * sz)) - 64'd1;
    val  = (longint'(word) >> (8 * off)) & mask;
    if (ref_signed(wm) && val[8 * sz - 1]) val = val | (~mask);
    return val[31:0];
  endfunction

  // One complete load on instance k; checks every cycle from accept to IDLE.
  // The correct word is on mem_rdata only in the cycle before the sample edge.
  task automatic do_load(input int k, input logic [31:0] addr, input logic [2:0] wm,
                         input logic [4:0] dst, input logic [31:0] word,
                         input logic [31:0] exp, input int hold);
    int lat;
    lat = LATS[k];
    @(negedge clk);
    req_valid[k]    = 1'b1;
    req_addr[k]     = addr;
    req_wordmode[k] = wm;
    req_dst[k]      = dst;
    mem_rdata[k]    = $urandom;
    ld_ready[k]     = 1'b0;
    check("ready_before_accept", 32'(req_ready[k]), 32'd1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    if (ref_misaligned(addr, wm)) begin
      check("adel_pulse", 32'(adel[k]), 32'd1);
      check("adel_addr", adel_addr[k], addr);
      check("adel_no_ren", 32'(mem_ren[k]), 32'd0);
      check("adel_ready", 32'(req_ready[k]), 32'd1);
      check("adel_no_valid", 32'(ld_valid[k]), 32'd0);
      @(posedge clk); #1;
      check("adel_end", 32'(adel[k]), 32'd0);
      check("adel_end_ren", 32'(mem_ren[k]), 32'd0);
      check("adel_end_valid", 32'(ld_valid[k]), 32'd0);
      check("adel_addr_held", adel_addr[k], addr);
      return;
    end
    for (int c = 1; c <= lat + 1; c++) begin
      mem_rdata[k] = (c == lat + 1) ? word : $urandom;
      check("busy_no_valid", 32'(ld_valid[k]), 32'd0);
      check("mem_ren", 32'(mem_ren[k]), (c == 1) ? 32'd1 : 32'd0);
      check("busy_ready", 32'(req_ready[k]), 32'd0);
      check("mem_addr", mem_addr[k], {addr[31:2], 2'b00});
      check("no_adel", 32'(adel[k]), 32'd0);
      @(posedge clk); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      mem_rdata[k] = $urandom;
      check("ld_valid", 32'(ld_valid[k]), 32'd1);
      check("ld_data", ld_data[k], exp);
      check("ld_dst", 32'(ld_dst[k]), 32'(dst));
      check("done_ren", 32'(mem_ren[k]), 32'd0);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    ld_ready[k] = 1'b1;
    @(posedge clk); #1;
    ld_ready[k] = 1'b0;
    check("idle_valid", 32'(ld_valid[k]), 32'd0);
    check("idle_ready", 32'(req_ready[k]), 32'd1);
  endtask

  task automatic rand_load(input int k);
    logic [31:0] addr, word;
    logic [2:0]  wm;
    logic [4:0]  dst;
    addr = $urandom;
    word = $urandom;
    wm   = 3'($urandom_range(0, 7));
    dst  = 5'($urandom);
    do_load(k, addr, wm, dst, word, ref_load(word, addr, wm), $urandom_range(0, 3));
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_valid[k]    = 1'b0;
      req_addr[k]     = 32'h0;
      req_wordmode[k] = WM_WD;
      req_dst[k]      = 5'd0;
      mem_rdata[k]    = 32'h0;
      ld_ready[k]     = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_ren", 32'(mem_ren[k]), 32'd0);
      check("rst_valid", 32'(ld_valid[k]), 32'd0);
      check("rst_adel", 32'(adel[k]), 32'd0);
      check("rst_mem_addr", mem_addr[k], 32'h0);
      check("rst_ld_data", ld_data[k], 32'h0);
      check("rst_adel_addr", adel_addr[k], 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) check("rst_ready", 32'(req_ready[k]), 32'd1);

    // Directed loads on the RD_LATENCY=1 instance.
    do_load(1, 32'h100, WM_WD, 5'd3,  32'h8899AABB, 32'h8899AABB, 0);
    do_load(1, 32'h103, WM_BS, 5'd4,  32'h80FF1234, 32'hFFFFFF80, 0);
    do_load(1, 32'h103, WM_BU, 5'd5,  32'h80FF1234, 32'h00000080, 0);
    do_load(1, 32'h102, WM_HS, 5'd6,  32'h80FF1234, 32'hFFFF80FF, 0);
    do_load(1, 32'h100, WM_HU, 5'd7,  32'h80FF1234, 32'h00001234, 0);
    do_load(1, 32'h102, WM_WD, 5'd8,  32'h0,        32'h0,        0);
    do_load(1, 32'h101, WM_HS, 5'd9,  32'h0,        32'h0,        0);
    do_load(1, 32'h204, WM_BS, 5'd31, 32'h00007F00, 32'h00000000, 5);
    do_load(1, 32'h205, WM_BS, 5'd17, 32'h00007F00, 32'h0000007F, 0);

    // Latency boundaries on every instance.
    for (int k = 0; k < NI; k++)
      do_load(k, 32'h001, WM_BU, 5'd10, 32'h0000AB00, 32'h000000AB, 1);

    // Reset while the RD_LATENCY=4 instance is waiting for read data.
    @(negedge clk);
    req_valid[2]    = 1'b1;
    req_addr[2]     = 32'h0000_0040;
    req_wordmode[2] = WM_WD;
    req_dst[2]      = 5'd12;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    check("wait_busy", 32'(req_ready[2]), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_ready", 32'(req_ready[2]), 32'd1);
    check("midrst_ren", 32'(mem_ren[2]), 32'd0);
    check("midrst_valid", 32'(ld_valid[2]), 32'd0);
    check("midrst_mem_addr", mem_addr[2], 32'h0);
    check("midrst_ld_data", ld_data[2], 32'h0);
    check("midrst_ld_dst", 32'(ld_dst[2]), 32'd0);
    for (int c = 0; c < 8; c++) begin
      mem_rdata[2] = $urandom;
      @(posedge clk); #1;
      check("midrst_no_valid", 32'(ld_valid[2]), 32'd0);
      check("midrst_no_ren", 32'(mem_ren[2]), 32'd0);
    end
    check("midrst_data_zero", ld_data[2], 32'h0);

    // Randomized loads on all instances.
    for (int i = 0; i < 40; i++)
      for (int k = 0; k < NI; k++) rand_load(k);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
